// File: rtl/dec_reconstruct4_if.sv
// Block-level bus for the 4x4 decoder reconstruct unit: request, coefficient
// and prediction inputs, and the reconstructed block with its status flags.
interface dec_reconstruct4_if;
  logic         start;
  logic [255:0] YLevels;
  logic [255:0] q;
  logic [127:0] YPred;
  logic [127:0] Yout;
  logic         nz;
  logic         busy;
  logic         done;

  // Upstream side (coefficient parser / bench) drives the request.
  modport master (
    output start, YLevels, q, YPred,
    input  Yout, nz, busy, done
  );

  // Reconstruct unit side.
  modport slave (
    input  start, YLevels, q, YPred,
    output Yout, nz, busy, done
  );
endinterface

// File: rtl/dec_reconstruct4.sv
// 4x4 luma reconstruct for the decoder: zigzag dequant, VP8 inverse transform
// (one column per cycle, then one row per cycle) and clipped prediction add.
// An all-zero block skips the transform and returns the prediction directly.
module dec_reconstruct4 #(
  parameter int BLOCK_SIZE = 4
) (
  input logic          clk,
  input logic          rst_n,
  dec_reconstruct4_if.slave bus
);
  localparam int N  = BLOCK_SIZE;
  localparam int NC = N * N;
  localparam logic signed [17:0] K1 = 18'sd85627;  // 20091 + 65536
  localparam logic signed [17:0] K2 = 18'sd35468;
  // Raster position j -> zigzag index n (inverse of {0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15}).
  localparam int IZZ [NC] = '{0, 1, 5, 6, 2, 4, 7, 12, 3, 8, 11, 13, 9, 10, 14, 15};

  typedef enum logic [2:0] {S_IDLE, S_DEQ, S_VPASS, S_HPASS, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [1:0]         r_cnt;
  logic signed [15:0] r_lvl  [NC];
  logic [15:0]        r_q    [NC];
  logic [7:0]         r_pred [NC];
  logic signed [15:0] r_coef [NC];
  logic signed [19:0] r_t    [N][N];
  logic [7:0]         r_yout [NC];
  logic               r_nz;

  logic               w_accept;
  logic               w_nz_in;
  logic               w_busy;
  logic               w_done;
  logic signed [15:0] w_coef [NC];
  logic signed [19:0] w_x    [N];
  logic signed [19:0] w_v    [N];
  logic signed [19:0] w_bias;
  logic signed [19:0] w_a, w_b, w_cc, w_d;
  logic signed [20:0] w_sum  [N];
  logic [7:0]         w_pix  [N];
  logic [127:0]       w_yout_flat;

  // (x * K) >>> 16, truncated to the 20-bit transform width.
  function automatic logic signed [19:0] mulk(input logic signed [19:0] x,
                                              input logic signed [17:0] k);
    logic signed [37:0] p;
    p = {{18{x[19]}}, x} * {{20{k[17]}}, k};
    return 20'(p >>> 16);
  endfunction

  assign w_accept = bus.start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_nz_in  = |bus.YLevels;

  // Dequantisation: each raster coefficient picks its level through the inverse zigzag.
  generate
    for (genvar gi = 0; gi < NC; gi++) begin : g_deq
      assign w_coef[gi] = 16'(r_lvl[IZZ[gi]] * $signed({1'b0, r_q[gi]}));
    end
  endgenerate

  // Shared 1-D butterfly: columns of coef in VPASS, rows of t in HPASS (with +4 rounding).
  always_comb begin
    for (int k = 0; k < N; k++) begin
      if (r_state == S_HPASS) begin
        w_x[k] = r_t[k][r_cnt];
      end else begin
        w_x[k] = {{4{r_coef[{2'(k), r_cnt}][15]}}, r_coef[{2'(k), r_cnt}]};
      end
    end
    w_bias = (r_state == S_HPASS) ? 20'sd4 : 20'sd0;
    w_a    = w_x[0] + w_bias + w_x[2];
    w_b    = w_x[0] + w_bias - w_x[2];
    w_cc   = mulk(w_x[1], K2) - mulk(w_x[3], K1);
    w_d    = mulk(w_x[1], K1) + mulk(w_x[3], K2);
    w_v[0] = w_a + w_d;
    w_v[1] = w_b + w_cc;
    w_v[2] = w_b - w_cc;
    w_v[3] = w_a - w_d;
  end

  // Prediction add and clip to 0..255 for the row currently in HPASS.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      w_sum[k] = $signed({13'd0, r_pred[{r_cnt, 2'(k)}]}) + $signed({w_v[k][19], (w_v[k] >>> 3)});
      if (w_sum[k] < 21'sd0) begin
        w_pix[k] = 8'd0;
      end else if (w_sum[k] > 21'sd255) begin
        w_pix[k] = 8'd255;
      end else begin
        w_pix[k] = w_sum[k][7:0];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; start is honoured only in IDLE or DONE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          w_state_next = w_nz_in ? S_DEQ : S_DONE;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_DEQ:   w_state_next = S_VPASS;
      S_VPASS: w_state_next = (r_cnt == 2'd3) ? S_HPASS : S_VPASS;
      S_HPASS: w_state_next = (r_cnt == 2'd3) ? S_DONE : S_HPASS;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    w_busy = (r_state == S_DEQ) || (r_state == S_VPASS) || (r_state == S_HPASS);
    w_done = (r_state == S_DONE);
  end

  // Datapath: capture on accept, dequant, column pass into t, row pass into Yout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 2'd0;
      r_nz  <= 1'b0;
      for (int i = 0; i < NC; i++) begin
        r_lvl[i]  <= '0;
        r_q[i]    <= '0;
        r_pred[i] <= '0;
        r_coef[i] <= '0;
        r_yout[i] <= '0;
      end
      for (int c = 0; c < N; c++) begin
        for (int k = 0; k < N; k++) begin
          r_t[c][k] <= '0;
        end
      end
    end else if (w_accept) begin
      r_cnt <= 2'd0;
      r_nz  <= w_nz_in;
      for (int i = 0; i < NC; i++) begin
        r_lvl[i]  <= bus.YLevels[16*i +: 16];
        r_q[i]    <= bus.q[16*i +: 16];
        r_pred[i] <= bus.YPred[8*i +: 8];
        if (!w_nz_in) begin
          r_yout[i] <= bus.YPred[8*i +: 8];
        end
      end
    end else begin
      case (r_state)
        S_DEQ: begin
          for (int i = 0; i < NC; i++) begin
            r_coef[i] <= w_coef[i];
          end
        end
        S_VPASS: begin
          for (int k = 0; k < N; k++) begin
            r_t[r_cnt][k] <= w_v[k];
          end
          r_cnt <= r_cnt + 2'd1;
        end
        S_HPASS: begin
          for (int k = 0; k < N; k++) begin
            r_yout[{r_cnt, 2'(k)}] <= w_pix[k];
          end
          r_cnt <= r_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Flatten the pixel array onto the output bus.
  always_comb begin
    w_yout_flat = '0;
    for (int i = 0; i < NC; i++) begin
      w_yout_flat[8*i +: 8] = r_yout[i];
    end
  end

  assign bus.Yout = w_yout_flat;
  assign bus.nz   = r_nz;
  assign bus.busy = w_busy;
  assign bus.done = w_done;
endmodule
